// File: rtl/mpf_vtp_csr_responder_if.sv
// ============================================================================
// Module : mpf_vtp_csr_responder_if
// Brief  : CSR request/response bus plus invalidation handshake for the VTP
//          CSR responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mpf_vtp_csr_responder_if #(
    parameter int CSR_IDX_WIDTH = 4
);
    logic [CSR_IDX_WIDTH-1:0] csr_req_idx;
    logic                     rd_req_en;
    logic                     wr_req_en;
    logic [63:0]              wr_data;
    logic [63:0]              dfh_value;
    logic                     rd_rsp_valid;
    logic [63:0]              rd_data;
    logic                     inval_valid;
    logic                     inval_all;
    logic [63:0]              inval_vaddr;
    logic                     inval_ready;

    modport slave (
        input  csr_req_idx, rd_req_en, wr_req_en, wr_data, dfh_value, inval_ready,
        output rd_rsp_valid, rd_data, inval_valid, inval_all, inval_vaddr
    );

    modport master (
        output csr_req_idx, rd_req_en, wr_req_en, wr_data, dfh_value, inval_ready,
        input  rd_rsp_valid, rd_data, inval_valid, inval_all, inval_vaddr
    );
endinterface

`default_nettype wire

// File: rtl/mpf_vtp_csr_responder.sv
// ============================================================================
// Module : mpf_vtp_csr_responder
// Brief  : VTP-side CSR slave: control registers, invalidation launcher and
//          saturating hit/miss/fail statistics counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mpf_vtp_csr_responder #(
    parameter int          CSR_IDX_WIDTH = 4,
    parameter logic [63:0] VTP_UUID_LO   = 64'h0,
    parameter logic [63:0] VTP_UUID_HI   = 64'h0,
    parameter int          N_CTR_BITS    = 48
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    mpf_vtp_csr_responder_if.slave  csr,
    output logic                    vtp_enable,
    output logic [63:0]             page_table_paddr,
    input  wire logic               stat_hit_inc,
    input  wire logic               stat_miss_inc,
    input  wire logic               stat_fail_inc
);

    localparam logic [CSR_IDX_WIDTH-1:0] c_IDX_DFH     = CSR_IDX_WIDTH'(0);
    localparam logic [CSR_IDX_WIDTH-1:0] c_IDX_UUID_LO = CSR_IDX_WIDTH'(1);
    localparam logic [CSR_IDX_WIDTH-1:0] c_IDX_UUID_HI = CSR_IDX_WIDTH'(2);
    localparam logic [CSR_IDX_WIDTH-1:0] c_IDX_MODE    = CSR_IDX_WIDTH'(4);
    localparam logic [CSR_IDX_WIDTH-1:0] c_IDX_PT      = CSR_IDX_WIDTH'(5);
    localparam logic [CSR_IDX_WIDTH-1:0] c_IDX_VADDR   = CSR_IDX_WIDTH'(6);
    localparam logic [CSR_IDX_WIDTH-1:0] c_IDX_STATUS  = CSR_IDX_WIDTH'(7);
    localparam logic [CSR_IDX_WIDTH-1:0] c_IDX_HIT     = CSR_IDX_WIDTH'(8);
    localparam logic [CSR_IDX_WIDTH-1:0] c_IDX_MISS    = CSR_IDX_WIDTH'(9);
    localparam logic [CSR_IDX_WIDTH-1:0] c_IDX_FAIL    = CSR_IDX_WIDTH'(10);
    localparam logic [N_CTR_BITS-1:0]    c_CTR_ONE     = N_CTR_BITS'(1);

    logic                  r_rd_valid;
    logic [63:0]           r_rd_data;
    logic                  r_enable;
    logic [63:12]          r_pt;
    logic                  r_inval_valid;
    logic                  r_inval_all;
    logic [63:12]          r_inval_vaddr;
    logic                  r_ovf;
    logic [N_CTR_BITS-1:0] r_ctr [3];

    logic        w_wr_mode;
    logic        w_wr_pt;
    logic        w_wr_vaddr;
    logic        w_wr_status;
    logic        w_cmd;
    logic        w_slot_free;
    logic [2:0]  w_clr;
    logic [2:0]  w_inc;
    logic [63:0] w_rd_mux;
    logic        w_unused;

    assign w_wr_mode   = csr.wr_req_en && (csr.csr_req_idx == c_IDX_MODE);
    assign w_wr_pt     = csr.wr_req_en && (csr.csr_req_idx == c_IDX_PT);
    assign w_wr_vaddr  = csr.wr_req_en && (csr.csr_req_idx == c_IDX_VADDR);
    assign w_wr_status = csr.wr_req_en && (csr.csr_req_idx == c_IDX_STATUS);
    assign w_clr       = {csr.wr_req_en && (csr.csr_req_idx == c_IDX_FAIL),
                          csr.wr_req_en && (csr.csr_req_idx == c_IDX_MISS),
                          csr.wr_req_en && (csr.csr_req_idx == c_IDX_HIT)};
    assign w_inc       = {stat_fail_inc, stat_miss_inc, stat_hit_inc};
    assign w_unused    = ^csr.wr_data[11:2];

    // A command can launch when the slot is empty or is being emptied this cycle
    assign w_cmd       = (w_wr_mode && csr.wr_data[1]) || w_wr_vaddr;
    assign w_slot_free = !r_inval_valid || csr.inval_ready;

    always_comb begin
        w_rd_mux = '0;
        case (csr.csr_req_idx)
            c_IDX_DFH:     w_rd_mux = csr.dfh_value;
            c_IDX_UUID_LO: w_rd_mux = VTP_UUID_LO;
            c_IDX_UUID_HI: w_rd_mux = VTP_UUID_HI;
            c_IDX_MODE:    w_rd_mux = {63'b0, r_enable};
            c_IDX_PT:      w_rd_mux = {r_pt, 12'h0};
            c_IDX_STATUS:  w_rd_mux = {62'b0, r_ovf, r_inval_valid};
            c_IDX_HIT:     w_rd_mux = 64'(r_ctr[0]);
            c_IDX_MISS:    w_rd_mux = 64'(r_ctr[1]);
            c_IDX_FAIL:    w_rd_mux = 64'(r_ctr[2]);
            default:       w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_enable      <= 1'b0;
            r_pt          <= '0;
            r_inval_valid <= 1'b0;
            r_inval_all   <= 1'b0;
            r_inval_vaddr <= '0;
            r_ovf         <= 1'b0;
        end else begin
            r_rd_valid <= csr.rd_req_en;
            if (csr.rd_req_en) begin
                r_rd_data <= w_rd_mux;
            end
            if (w_wr_mode) begin
                r_enable <= csr.wr_data[0];
            end
            if (w_wr_pt) begin
                r_pt <= csr.wr_data[63:12];
            end
            if (w_cmd && w_slot_free) begin
                r_inval_valid <= 1'b1;
                r_inval_all   <= !w_wr_vaddr;
                r_inval_vaddr <= w_wr_vaddr ? csr.wr_data[63:12] : '0;
            end else if (csr.inval_ready) begin
                r_inval_valid <= 1'b0;
            end
            if (w_cmd && !w_slot_free) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && csr.wr_data[1]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Clear beats a coincident increment; counters stick at all ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                r_ctr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_clr[i]) begin
                    r_ctr[i] <= '0;
                end else if (w_inc[i] && !(&r_ctr[i])) begin
                    r_ctr[i] <= r_ctr[i] + c_CTR_ONE;
                end
            end
        end
    end

    assign csr.rd_rsp_valid = r_rd_valid;
    assign csr.rd_data      = r_rd_data;
    assign csr.inval_valid  = r_inval_valid;
    assign csr.inval_all    = r_inval_all;
    assign csr.inval_vaddr  = {r_inval_vaddr, 12'h0};
    assign vtp_enable       = r_enable;
    assign page_table_paddr = {r_pt, 12'h0};

endmodule

`default_nettype wire
